// File: rtl/reg_arb_pkg.sv
// Shared widths, grant-source encoding and request type for the register write arbiter.
package reg_arb_pkg;

  localparam int REGISTER_WIDTH_DEF   = 8;
  localparam int LOG_OF_REGISTERS_DEF = 4;
  localparam int NUM_PERIPH_DEF       = 2;
  localparam int STARVE_LIMIT_DEF     = 4;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CPU,
    SRC_PERIPH
  } grant_src_t;

  typedef struct packed {
    logic [LOG_OF_REGISTERS_DEF-1:0] dest;
    logic [REGISTER_WIDTH_DEF-1:0]   value;
  } write_req_t;

  // Width of an index/counter that must hold values 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_periph_slot.sv
// One-deep peripheral write buffer with a saturating wait counter that flags starvation.
module periph_slot
  import reg_arb_pkg::*;
#(
  parameter int REGISTER_WIDTH   = REGISTER_WIDTH_DEF,
  parameter int LOG_OF_REGISTERS = LOG_OF_REGISTERS_DEF,
  parameter int STARVE_LIMIT     = STARVE_LIMIT_DEF
) (
  input  logic                        clock,
  input  logic                        isReset,
  input  logic                        offer_valid,
  input  logic [LOG_OF_REGISTERS-1:0] offer_register,
  input  logic [REGISTER_WIDTH-1:0]   offer_value,
  input  logic                        grant,
  output logic                        ready,
  output logic                        full,
  output logic                        starving,
  output logic [LOG_OF_REGISTERS-1:0] held_register,
  output logic [REGISTER_WIDTH-1:0]   held_value
);

  localparam int WW = idx_width(STARVE_LIMIT + 1);

  logic [WW-1:0] wait_cnt;
  logic          accept;

  // A granted slot drains this cycle, so it can refill at the same edge.
  assign ready    = !isReset && (!full || grant);
  assign accept   = offer_valid && ready;
  assign starving = full && (wait_cnt == WW'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (isReset) begin
      full          <= 1'b0;
      wait_cnt      <= '0;
      held_register <= '0;
      held_value    <= '0;
    end else if (accept) begin
      full          <= 1'b1;
      wait_cnt      <= '0;
      held_register <= offer_register;
      held_value    <= offer_value;
    end else if (grant) begin
      full     <= 1'b0;
      wait_cnt <= '0;
    end else if (full && (wait_cnt != WW'(STARVE_LIMIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between CPU write-back and buffered peripheral writers.
// Optional ARB_STALL_COUNT_EN adds a saturating count of CPU stall cycles on stallCount.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int REGISTER_WIDTH   = REGISTER_WIDTH_DEF,
  parameter int LOG_OF_REGISTERS = LOG_OF_REGISTERS_DEF,
  parameter int NUM_PERIPH       = NUM_PERIPH_DEF,
  parameter int STARVE_LIMIT     = STARVE_LIMIT_DEF
) (
  input  logic                                   clock,
  input  logic                                   isReset,
  input  logic                                   cpuWriteEnable,
  input  logic [LOG_OF_REGISTERS-1:0]            cpuRegister,
  input  logic [REGISTER_WIDTH-1:0]              cpuValue,
  output logic                                   cpuStall,
  input  logic [NUM_PERIPH-1:0]                  periphValid,
  input  logic [NUM_PERIPH*LOG_OF_REGISTERS-1:0] periphRegister,
  input  logic [NUM_PERIPH*REGISTER_WIDTH-1:0]   periphValue,
  output logic [NUM_PERIPH-1:0]                  periphReady,
  output logic                                   writeEnable,
  output logic [LOG_OF_REGISTERS-1:0]            writeRegister,
  output logic [REGISTER_WIDTH-1:0]              writeValue
`ifdef ARB_STALL_COUNT_EN
 ,output logic [15:0]                            stallCount
`endif
);

  localparam int PW = idx_width(NUM_PERIPH);

  logic [NUM_PERIPH-1:0]       slot_full;
  logic [NUM_PERIPH-1:0]       slot_starving;
  logic [NUM_PERIPH-1:0]       slot_grant;
  logic [LOG_OF_REGISTERS-1:0] slot_register [NUM_PERIPH];
  logic [REGISTER_WIDTH-1:0]   slot_value    [NUM_PERIPH];

  logic [PW-1:0]               rr_ptr;
  grant_src_t                  grant_src;
  logic [PW-1:0]               grant_idx;
  logic [LOG_OF_REGISTERS-1:0] win_register;
  logic [REGISTER_WIDTH-1:0]   win_value;

  for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_slot
    periph_slot #(
      .REGISTER_WIDTH   (REGISTER_WIDTH),
      .LOG_OF_REGISTERS (LOG_OF_REGISTERS),
      .STARVE_LIMIT     (STARVE_LIMIT)
    ) u_slot (
      .clock          (clock),
      .isReset        (isReset),
      .offer_valid    (periphValid[i]),
      .offer_register (periphRegister[i*LOG_OF_REGISTERS +: LOG_OF_REGISTERS]),
      .offer_value    (periphValue[i*REGISTER_WIDTH +: REGISTER_WIDTH]),
      .grant          (slot_grant[i]),
      .ready          (periphReady[i]),
      .full           (slot_full[i]),
      .starving       (slot_starving[i]),
      .held_register  (slot_register[i]),
      .held_value     (slot_value[i])
    );
  end

  // First set bit of mask searching upward from ptr, wrapping.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_PERIPH-1:0] mask,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_PERIPH);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    grant_src    = SRC_NONE;
    grant_idx    = '0;
    slot_grant   = '0;
    win_register = '0;
    win_value    = '0;
    if (|slot_starving) begin
      grant_src = SRC_PERIPH;
      grant_idx = rr_pick(slot_starving, rr_ptr);
    end else if (cpuWriteEnable) begin
      grant_src = SRC_CPU;
    end else if (|slot_full) begin
      grant_src = SRC_PERIPH;
      grant_idx = rr_pick(slot_full, rr_ptr);
    end
    if (grant_src == SRC_CPU) begin
      win_register = cpuRegister;
      win_value    = cpuValue;
    end else if (grant_src == SRC_PERIPH) begin
      win_register          = slot_register[grant_idx];
      win_value             = slot_value[grant_idx];
      slot_grant[grant_idx] = 1'b1;
    end
  end

  assign cpuStall = !isReset && cpuWriteEnable && (grant_src != SRC_CPU);

  // Register 0 reads as zero, so a grant to it is consumed without a strobe.
  always_ff @(posedge clock) begin
    if (isReset) begin
      rr_ptr        <= '0;
      writeEnable   <= 1'b0;
      writeRegister <= '0;
      writeValue    <= '0;
    end else begin
      writeEnable <= (grant_src != SRC_NONE) && (win_register != '0);
      if ((grant_src != SRC_NONE) && (win_register != '0)) begin
        writeRegister <= win_register;
        writeValue    <= win_value;
      end
      if (grant_src == SRC_PERIPH) begin
        rr_ptr <= (grant_idx == PW'(NUM_PERIPH - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

`ifdef ARB_STALL_COUNT_EN
  always_ff @(posedge clock) begin
    if (isReset) begin
      stallCount <= '0;
    end else if (cpuStall && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded bench for reg_write_arbiter: expected writes are queued as stimulus is driven.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int W = REGISTER_WIDTH_DEF;
  localparam int L = LOG_OF_REGISTERS_DEF;
  localparam int N = 2;

  logic           clock = 1'b0;
  logic           isReset = 1'b1;
  logic           cpuWriteEnable = 1'b0;
  logic [L-1:0]   cpuRegister = '0;
  logic [W-1:0]   cpuValue = '0;
  logic           cpuStall;
  logic [N-1:0]   periphValid = '0;
  logic [N*L-1:0] periphRegister = '0;
  logic [N*W-1:0] periphValue = '0;
  logic [N-1:0]   periphReady;
  logic           writeEnable;
  logic [L-1:0]   writeRegister;
  logic [W-1:0]   writeValue;
`ifdef ARB_STALL_COUNT_EN
  logic [15:0]    stallCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  write_req_t sb[$];
  write_req_t mon_exp;

  reg_write_arbiter #(
    .REGISTER_WIDTH   (W),
    .LOG_OF_REGISTERS (L),
    .NUM_PERIPH       (N),
    .STARVE_LIMIT     (STARVE_LIMIT_DEF)
  ) dut (
    .clock          (clock),
    .isReset        (isReset),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuRegister    (cpuRegister),
    .cpuValue       (cpuValue),
    .cpuStall       (cpuStall),
    .periphValid    (periphValid),
    .periphRegister (periphRegister),
    .periphValue    (periphValue),
    .periphReady    (periphReady),
    .writeEnable    (writeEnable),
    .writeRegister  (writeRegister),
    .writeValue     (writeValue)
`ifdef ARB_STALL_COUNT_EN
   ,.stallCount     (stallCount)
`endif
  );

  always #5 clock = ~clock;

  // Every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (writeEnable === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got reg %0d value %h, required no write", writeRegister, writeValue);
      end else begin
        mon_exp = sb.pop_front();
        if ({writeRegister, writeValue} !== {mon_exp.dest, mon_exp.value}) begin
          miscompares++;
          $display("FAIL write_data: got reg %0d value %h, required reg %0d value %h",
                   writeRegister, writeValue, mon_exp.dest, mon_exp.value);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpuWriteEnable = 1'b0;
    cpuRegister    = '0;
    cpuValue       = '0;
    periphValid    = '0;
    periphRegister = '0;
    periphValue    = '0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    isReset = 1'b1;
    tick();
    isReset = 1'b0;
  endtask

  task automatic push_write(input int r, input int v);
    write_req_t e;
    e.dest  = L'(r);
    e.value = W'(v);
    sb.push_back(e);
  endtask

  task automatic test_drained(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    isReset        = 1'b1;
    cpuWriteEnable = 1'b1;
    cpuRegister    = 4'd3;
    cpuValue       = 8'h77;
    periphValid    = 2'b11;
    periphRegister = {4'd5, 4'd4};
    periphValue    = 16'h1122;
    tick();
    tick();
    vectors++;
    if ({writeEnable, writeRegister, writeValue} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b reg=%0d val=%h, required all 0", writeEnable, writeRegister, writeValue);
    end
    vectors++;
    if (cpuStall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cpu_stall: got %b, required 0", cpuStall);
    end
    vectors++;
    if (periphReady !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_periph_ready: got %b, required 00", periphReady);
    end
    isReset = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (periphReady !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_slots_empty: got ready %b, required 11", periphReady);
    end
    tick();
    vectors++;
    if (writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_we: got %b, required 0", writeEnable);
    end
  endtask

  task automatic test_cpu_only();
    int r;
    int v;
    cpuWriteEnable = 1'b1;
    cpuRegister    = 4'd3;
    cpuValue       = 8'h5A;
    #1;
    vectors++;
    if (cpuStall !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_only_stall: got %b, required 0", cpuStall);
    end
    push_write(3, 'h5A);
    tick();
    vectors++;
    if ({writeEnable, writeRegister, writeValue} !== {1'b1, 4'd3, 8'h5A}) begin
      miscompares++;
      $display("FAIL cpu_only_write: got we=%b reg=%0d val=%h, required we=1 reg=3 val=5a",
               writeEnable, writeRegister, writeValue);
    end
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(1, 15));
      v = int'($urandom_range(0, 255));
      cpuRegister = L'(r);
      cpuValue    = W'(v);
      push_write(r, v);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    test_drained("cpu_only");
  endtask

  task automatic test_starvation();
    int cv;
    logic exp_stall;
    for (int c = 0; c <= 6; c++) begin
      cv = (c < 5) ? c : 5;
      cpuWriteEnable = 1'b1;
      cpuRegister    = 4'd2;
      cpuValue       = W'(8'h10 + cv);
      if (c == 0) begin
        periphValid       = 2'b01;
        periphRegister    = {4'd0, 4'd9};
        periphValue       = {8'h00, 8'hF9};
      end else begin
        periphValid = 2'b00;
      end
      #1;
      exp_stall = (c == 5);
      vectors++;
      if (cpuStall !== exp_stall) begin
        miscompares++;
        $display("FAIL starve_stall_c%0d: got %b, required %b", c, cpuStall, exp_stall);
      end
      if (c >= 1 && c <= 5) begin
        vectors++;
        if (periphReady[0] !== (c == 5)) begin
          miscompares++;
          $display("FAIL starve_ready_c%0d: got %b, required %b", c, periphReady[0], (c == 5));
        end
      end
      if (c == 5) push_write(9, 'hF9);
      else        push_write(2, 'h10 + cv);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    test_drained("starvation");
  endtask

  task automatic test_round_robin();
    int a_idx;
    int b_idx;
    int s;
    logic [N-1:0] exp_ready;
    a_idx = 0;
    b_idx = 0;
    reset_pulse();
    for (int k = 0; k <= 10; k++) begin
      periphValid    = (k <= 8) ? 2'b11 : 2'b00;
      periphRegister = {4'd5, 4'd4};
      periphValue    = {W'(8'hB0 + b_idx), W'(8'hA0 + a_idx)};
      #1;
      if (k <= 8) begin
        exp_ready = (k == 0) ? 2'b11 : ((k % 2 == 1) ? 2'b01 : 2'b10);
        vectors++;
        if (periphReady !== exp_ready) begin
          miscompares++;
          $display("FAIL rr_ready_k%0d: got %b, required %b", k, periphReady, exp_ready);
        end
        if (exp_ready[0]) a_idx++;
        if (exp_ready[1]) b_idx++;
      end
      if (k >= 1) begin
        s = (k - 1) % 2;
        push_write(4 + s, ((s == 1) ? 'hB0 : 'hA0) + (k - 1) / 2);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    test_drained("round_robin");
  endtask

  task automatic test_register_zero();
    cpuWriteEnable = 1'b1;
    cpuRegister    = 4'd0;
    cpuValue       = 8'hFF;
    #1;
    vectors++;
    if (cpuStall !== 1'b0) begin
      miscompares++;
      $display("FAIL reg0_cpu_stall: got %b, required 0", cpuStall);
    end
    tick();
    vectors++;
    if (writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL reg0_cpu_we: got %b, required 0", writeEnable);
    end
    cpuRegister = 4'd1;
    cpuValue    = 8'h3C;
    push_write(1, 'h3C);
    tick();
    idle_inputs();
    periphValid    = 2'b10;
    periphRegister = {4'd0, 4'd0};
    periphValue    = {8'h55, 8'h00};
    tick();
    periphValid = 2'b00;
    #1;
    vectors++;
    if (periphReady[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL reg0_periph_grant_ready: got %b, required 1", periphReady[1]);
    end
    tick();
    vectors++;
    if (writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL reg0_periph_we: got %b, required 0", writeEnable);
    end
    vectors++;
    if (periphReady !== 2'b11) begin
      miscompares++;
      $display("FAIL reg0_periph_consumed: got ready %b, required 11", periphReady);
    end
    tick();
    test_drained("register_zero");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 2; c++) begin
      cpuWriteEnable = 1'b1;
      cpuRegister    = 4'd6;
      cpuValue       = W'(8'h60 + c);
      periphValid    = (c == 0) ? 2'b10 : 2'b00;
      periphRegister = {4'd7, 4'd0};
      periphValue    = {8'h77, 8'h00};
      push_write(6, 'h60 + c);
      tick();
    end
    isReset        = 1'b1;
    cpuValue       = 8'h63;
    periphValid    = 2'b10;
    periphValue    = {8'h88, 8'h00};
    #1;
    vectors++;
    if ({cpuStall, periphReady} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_reset_comb: got stall=%b ready=%b, required 0 and 00", cpuStall, periphReady);
    end
    tick();
    vectors++;
    if ({writeEnable, writeRegister, writeValue} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got we=%b reg=%0d val=%h, required all 0", writeEnable, writeRegister, writeValue);
    end
    isReset = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (periphReady !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_reset_slot_empty: got ready %b, required 11", periphReady);
    end
    repeat (8) tick();
    test_drained("reset_mid");
  endtask

`ifdef ARB_STALL_COUNT_EN
  task automatic test_stall_count();
    reset_pulse();
    vectors++;
    if (stallCount !== 16'd0) begin
      miscompares++;
      $display("FAIL stall_count_reset: got %0d, required 0", stallCount);
    end
    repeat (3) test_starvation();
    vectors++;
    if (stallCount !== 16'd3) begin
      miscompares++;
      $display("FAIL stall_count_value: got %0d, required 3", stallCount);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_only();
    test_starvation();
    test_round_robin();
    test_register_zero();
    test_reset_mid();
`ifdef ARB_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
